vga_timing_gen: RTL and testbench

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_timing_gen.sv | 157 +++++++++++++++
 tb/tb_vga_timing_gen.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
// ----------------
// Parameterised VGA raster timing generator. Two free-running counters
// (h_cnt over pixels, v_cnt over lines) are decoded into sync, blanking,
// active-pixel coordinates and start-of-line / start-of-frame strobes.
//
// Every output is a register loaded from the decode of the counter values
// *before* they advance, so outputs trail the counters by exactly one
// enabled step. When pix_en is low, counters and level outputs hold, and
// the two strobes drop to 0 so they never stretch across idle cycles.
//
// Ports
//   vga_clk      in   pixel-domain clock
//   reset        in   asynchronous, active-high reset
//   pix_en       in   pixel-step enable
//   restart      in   synchronous return to the frame origin (ignores pix_en)
//   HS, VS       out  horizontal / vertical sync, asserted level HS_POL / VS_POL
//   blank_n      out  1 inside the visible region
//   x, y         out  active pixel coordinates, 0 outside the visible region
//   line_start   out  one-cycle strobe at the first pixel of a visible line
//   frame_start  out  one-cycle strobe at the first pixel of a frame
//   frame_cnt    out  16-bit completed-frame counter (only with FRAME_COUNT_EN)
//
// Optional feature macro: FRAME_COUNT_EN adds the frame_cnt port and logic.

module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int XW       = 10,
  parameter int YW       = 10
) (
  input  logic          vga_clk,
  input  logic          reset,
  input  logic          pix_en,
  input  logic          restart,
  output logic          HS,
  output logic          VS,
  output logic          blank_n,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          line_start,
  output logic          frame_start
`ifdef FRAME_COUNT_EN
  ,
  output logic [15:0]   frame_cnt
`endif
);

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // One spare count of headroom so the sync-end bound (which equals H_TOT
  // when the back porch is zero) is still representable.
  localparam int HCW = $clog2(H_TOT + 1);
  localparam int VCW = $clog2(V_TOT + 1);

  localparam logic [HCW-1:0] H_ACT_C  = HCW'(H_ACTIVE);
  localparam logic [HCW-1:0] H_SS_C   = HCW'(H_ACTIVE + H_FP);
  localparam logic [HCW-1:0] H_SE_C   = HCW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HCW-1:0] H_LAST_C = HCW'(H_TOT - 1);
  localparam logic [VCW-1:0] V_ACT_C  = VCW'(V_ACTIVE);
  localparam logic [VCW-1:0] V_SS_C   = VCW'(V_ACTIVE + V_FP);
  localparam logic [VCW-1:0] V_SE_C   = VCW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VCW-1:0] V_LAST_C = VCW'(V_TOT - 1);

  logic [HCW-1:0] h_cnt, h_nxt;
  logic [VCW-1:0] v_cnt, v_nxt;
  logic           h_last, v_last;
  logic           h_vis, v_vis;
  logic           hs_d, vs_d, blank_d, ls_d, fs_d;
  logic [XW-1:0]  x_d;
  logic [YW-1:0]  y_d;

  // Decode of the current (pre-increment) counter values.
  always_comb begin
    h_last  = (h_cnt == H_LAST_C);
    v_last  = (v_cnt == V_LAST_C);
    h_vis   = (h_cnt < H_ACT_C);
    v_vis   = (v_cnt < V_ACT_C);
    hs_d    = ((h_cnt >= H_SS_C) && (h_cnt < H_SE_C)) ? HS_POL : ~HS_POL;
    vs_d    = ((v_cnt >= V_SS_C) && (v_cnt < V_SE_C)) ? VS_POL : ~VS_POL;
    blank_d = h_vis && v_vis;
    x_d     = blank_d ? XW'(h_cnt) : '0;
    y_d     = blank_d ? YW'(v_cnt) : '0;
    ls_d    = (h_cnt == '0) && v_vis;
    fs_d    = (h_cnt == '0) && (v_cnt == '0);
  end

  // Counter advance: v_cnt moves only when h_cnt wraps.
  always_comb begin
    h_nxt = h_cnt + 1'b1;
    v_nxt = v_cnt;
    if (h_last) begin
      h_nxt = '0;
      v_nxt = v_last ? '0 : v_cnt + 1'b1;
    end
  end

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      HS          <= ~HS_POL;
      VS          <= ~VS_POL;
      blank_n     <= 1'b0;
      x           <= '0;
      y           <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (restart) begin
      // Restart takes priority over pix_en and over any wrap on this edge.
      h_cnt       <= '0;
      v_cnt       <= '0;
      HS          <= ~HS_POL;
      VS          <= ~VS_POL;
      blank_n     <= 1'b0;
      x           <= '0;
      y           <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (pix_en) begin
      h_cnt       <= h_nxt;
      v_cnt       <= v_nxt;
      HS          <= hs_d;
      VS          <= vs_d;
      blank_n     <= blank_d;
      x           <= x_d;
      y           <= y_d;
      line_start  <= ls_d;
      frame_start <= fs_d;
    end else begin
      // Idle step: levels hold, strobes must not linger.
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end
  end

`ifdef FRAME_COUNT_EN
  // Counts completed frames; only reset clears it, restart leaves it alone.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      frame_cnt <= '0;
    end else if (!restart && pix_en && h_last && v_last) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen using a small raster (15 x 8 counts) so that
// whole frames, wraps, restarts and resets fit in a short run.
module tb_vga_timing_gen;

  localparam int H_ACTIVE = 8;
  localparam int H_FP     = 2;
  localparam int H_SYNC   = 3;
  localparam int H_BP     = 2;
  localparam int V_ACTIVE = 4;
  localparam int V_FP     = 1;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 1;
  localparam bit HP       = 1'b0;
  localparam bit VP       = 1'b1;
  localparam int XW       = 4;
  localparam int YW       = 3;
  localparam int H_TOT    = H_ACTIVE + H_FP + H_SYNC + H_BP; // 15
  localparam int V_TOT    = V_ACTIVE + V_FP + V_SYNC + V_BP; // 8
  localparam int FRAME    = H_TOT * V_TOT;                   // 120
  localparam int W        = 5 + XW + YW;

  // clock / reset
  logic vga_clk = 1'b0;
  logic reset;
  logic pix_en;
  logic restart;
  always #5 vga_clk = ~vga_clk;

  logic          HS, VS, blank_n, line_start, frame_start;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
`ifdef FRAME_COUNT_EN
  logic [15:0]   frame_cnt;
`endif

  vga_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .HS_POL(HP), .VS_POL(VP), .XW(XW), .YW(YW)
  ) dut (
    .vga_clk(vga_clk),
    .reset(reset),
    .pix_en(pix_en),
    .restart(restart),
    .HS(HS),
    .VS(VS),
    .blank_n(blank_n),
    .x(x),
    .y(y),
    .line_start(line_start),
    .frame_start(frame_start)
`ifdef FRAME_COUNT_EN
    ,
    .frame_cnt(frame_cnt)
`endif
  );

  logic [W-1:0] dut_v;
  assign dut_v = {HS, VS, blank_n, x, y, line_start, frame_start};

  // scoreboard
  logic [W-1:0] exp_q[$];
  int           total = 0;
  int           bad   = 0;
  string        phase = "init";

  // reference model state
  int           m_h = 0;
  int           m_v = 0;
  logic [W-1:0] m_prev;
  logic [15:0]  m_fc = 16'd0;

  // Expected output word for a counter position, straight from the raster
  // definition: active, front porch, sync, back porch on both axes.
  function automatic logic [W-1:0] expect_at(input int h, input int v);
    logic          hs, vs, bl, ls, fs;
    logic [XW-1:0] xx;
    logic [YW-1:0] yy;
    hs = (h >= H_ACTIVE + H_FP && h < H_ACTIVE + H_FP + H_SYNC) ? HP : ~HP;
    vs = (v >= V_ACTIVE + V_FP && v < V_ACTIVE + V_FP + V_SYNC) ? VP : ~VP;
    bl = (h < H_ACTIVE) && (v < V_ACTIVE);
    xx = bl ? XW'(h) : '0;
    yy = bl ? YW'(v) : '0;
    ls = (h == 0) && (v < V_ACTIVE);
    fs = (h == 0) && (v == 0);
    return {hs, vs, bl, xx, yy, ls, fs};
  endfunction

  function automatic logic [W-1:0] reset_word();
    logic [XW-1:0] zx;
    logic [YW-1:0] zy;
    zx = '0;
    zy = '0;
    return {~HP, ~VP, 1'b0, zx, zy, 1'b0, 1'b0};
  endfunction

  task automatic cmp(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s/%s obs=%h exp=%h (HS,VS,blank_n,x,y,ls,fs)", phase, tag, obs, expv);
    end
  endtask

  task automatic cmp_int(input string tag, input int obs, input int expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s/%s obs=%0d exp=%0d", phase, tag, obs, expv);
    end
  endtask

  // Driver: apply one clock of stimulus, push the expected result, then
  // pop and compare on the following falling edge.
  task automatic drive(input logic en, input logic rs);
    logic [W-1:0] e;
    logic [W-1:0] got;
    pix_en  = en;
    restart = rs;
    if (rs) begin
      e   = reset_word();
      m_h = 0;
      m_v = 0;
    end else if (en) begin
      e = expect_at(m_h, m_v);
      if (m_h == H_TOT - 1) begin
        m_h = 0;
        if (m_v == V_TOT - 1) begin
          m_v  = 0;
          m_fc = m_fc + 16'd1;
        end else begin
          m_v++;
        end
      end else begin
        m_h++;
      end
    end else begin
      e = {m_prev[W-1:2], 2'b00};
    end
    m_prev = e;
    exp_q.push_back(e);
    @(posedge vga_clk);
    @(negedge vga_clk);
    got = exp_q.pop_front();
    cmp("step", dut_v, got);
`ifdef FRAME_COUNT_EN
    cmp_int("frame_cnt", int'(frame_cnt), int'(m_fc));
`endif
  endtask

  // Advance with pix_en=1 until the model sits at (h,v); bounded.
  task automatic run_to(input int h, input int v);
    for (int i = 0; i < 2 * FRAME && !(m_h == h && m_v == v); i++) drive(1'b1, 1'b0);
    if (!(m_h == h && m_v == v)) begin
      total++;
      bad++;
      $display("FAIL %s/run_to obs=(%0d,%0d) exp=(%0d,%0d)", phase, m_h, m_v, h, v);
    end
  endtask

  initial begin
    int hs_n, vs_n, bl_n, ls_n, fs_n;
    logic [W-1:0] rv;
    rv      = reset_word();
    reset   = 1'b1;
    pix_en  = 1'b0;
    restart = 1'b0;
    m_prev  = rv;

    // reset values
    phase = "reset";
    @(negedge vga_clk);
    cmp("reset_vals", dut_v, rv);
`ifdef FRAME_COUNT_EN
    cmp_int("reset_fc", int'(frame_cnt), 0);
`endif
    reset = 1'b0;

    // two frames free-running; tally one full frame of outputs
    phase = "run";
    drive(1'b1, 1'b0);
    cmp("first_step", dut_v, expect_at(0, 0));
    hs_n = 0; vs_n = 0; bl_n = 0; ls_n = 0; fs_n = 0;
    for (int i = 0; i < FRAME; i++) begin
      drive(1'b1, 1'b0);
      if (HS == HP) hs_n++;
      if (VS == VP) vs_n++;
      if (blank_n) bl_n++;
      if (line_start) ls_n++;
      if (frame_start) fs_n++;
    end
    cmp_int("hs_cycles", hs_n, H_SYNC * V_TOT);
    cmp_int("vs_cycles", vs_n, V_SYNC * H_TOT);
    cmp_int("blank_n_cycles", bl_n, H_ACTIVE * V_ACTIVE);
    cmp_int("line_starts", ls_n, V_ACTIVE);
    cmp_int("frame_starts", fs_n, 1);
    for (int i = 0; i < FRAME; i++) drive(1'b1, 1'b0);

    // pix_en toggling: half-rate raster, strobes one cycle wide
    phase = "toggle";
    ls_n = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      drive(i[0] == 1'b0, 1'b0);
      if (line_start) ls_n++;
    end
    cmp_int("toggle_line_starts", ls_n, V_ACTIVE);

    // random enable with occasional restart
    phase = "random";
    for (int i = 0; i < 300; i++)
      drive(1'($urandom_range(0, 1)), $urandom_range(0, 40) == 0);

    // restart mid-frame with pix_en high, then with pix_en low
    phase = "restart_mid";
    run_to(5, 2);
    drive(1'b1, 1'b1);
    drive(1'b1, 1'b0);
    run_to(11, 6);
    drive(1'b0, 1'b1);
    drive(1'b0, 1'b0);
    drive(1'b1, 1'b0);
    drive(1'b1, 1'b0);

    // restart on the frame wrap: frame count must not advance
    phase = "restart_wrap";
    run_to(H_TOT - 1, V_TOT - 1);
    drive(1'b1, 1'b1);
    drive(1'b1, 1'b0);

    // three full frames from the origin
    phase = "frames";
    for (int i = 0; i < 3 * FRAME; i++) drive(1'b1, 1'b0);

    // asynchronous reset mid-frame
    phase = "async_reset";
    run_to(11, 5);
    #2 reset = 1'b1;
    #1;
    cmp("async_vals", dut_v, rv);
`ifdef FRAME_COUNT_EN
    cmp_int("async_fc", int'(frame_cnt), 0);
`endif
    m_h = 0; m_v = 0; m_prev = rv; m_fc = 16'd0;
    pix_en = 1'b1;
    @(negedge vga_clk);
    cmp("reset_held", dut_v, rv);
    reset = 1'b0;
    drive(1'b1, 1'b0);
    for (int i = 0; i < FRAME + 7; i++) drive(1'b1, 1'b0);

    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain obs=%0d exp=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
